time_set_controller: RTL and testbench

- Front-panel writer for the clock/alarm core: turns push-button activity into the hour/minute BCD digits and the load strobes (time load, alarm load) that the core consumes.
- Seeds its edit registers from the core's current hour/minute digit outputs.
- Lets the user step hour and minute fields with wrap-around.
- Holds the chosen load strobe long enough for the core's one-second tick domain (one tick per 10 clocks) to sample it.

---
 rtl/time_set_pkg.sv | 68 ++++++
 rtl/time_set_controller_button_conditioner.sv | 66 ++++++
 rtl/time_set_controller.sv | 119 +++++++++++
 tb/tb_time_set_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// Shared types, limits and BCD helpers for the front-panel time/alarm setter.
package time_set_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EDIT_HOUR = 2'd1,
    EDIT_MIN  = 2'd2,
    LOAD      = 2'd3
  } state_e;

  localparam logic [1:0] FIELD_IDLE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_LOAD = 2'd3;

  localparam int HOUR_MAX         = 23;
  localparam int MIN_MAX          = 59;
  localparam int CORE_TICK_CYCLES = 10;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hhmm_t;

  function automatic int bcd_val(input logic [3:0] tens, input logic [3:0] units);
    return 10 * int'(tens) + int'(units);
  endfunction

  // A seed is usable only if every digit is a legal BCD digit and the fields are in range.
  function automatic logic seed_ok(input hhmm_t t);
    return (t.h0 <= 4'd9) && (t.m0 <= 4'd9) && (t.m1 <= 4'd5) &&
           (bcd_val({2'b00, t.h1}, t.h0) <= HOUR_MAX) &&
           (bcd_val(t.m1, t.m0) <= MIN_MAX);
  endfunction

  function automatic hhmm_t hour_inc(input hhmm_t t);
    hhmm_t r;
    r = t;
    if (bcd_val({2'b00, t.h1}, t.h0) >= HOUR_MAX) begin
      r.h1 = 2'd0;
      r.h0 = 4'd0;
    end else if (t.h0 == 4'd9) begin
      r.h1 = t.h1 + 2'd1;
      r.h0 = 4'd0;
    end else begin
      r.h0 = t.h0 + 4'd1;
    end
    return r;
  endfunction

  function automatic hhmm_t min_inc(input hhmm_t t);
    hhmm_t r;
    r = t;
    if (bcd_val(t.m1, t.m0) >= MIN_MAX) begin
      r.m1 = 4'd0;
      r.m0 = 4'd0;
    end else if (t.m0 == 4'd9) begin
      r.m1 = t.m1 + 4'd1;
      r.m0 = 4'd0;
    end else begin
      r.m0 = t.m0 + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/time_set_controller_button_conditioner.sv
// Raw button -> 2-flop sync -> optional level filter (ADD_DEBOUNCE_EN) -> one-cycle rising-edge pulse.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic edge_o
);

  logic sync1_q, sync2_q;
  logic prev_q, pulse_q;
  logic level;

  // History resets to "pressed" so a button held through reset must be released before it counts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef ADD_DEBOUNCE_EN
  logic        filt_q, filt_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = 16'd0;
    if (sync2_q != filt_q) begin
      if (cnt_q == 16'(DEBOUNCE_CYCLES - 1)) filt_d = sync2_q;
      else                                   cnt_d  = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_q <= 1'b1;
      cnt_q  <= 16'd0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= level;
      pulse_q <= level & ~prev_q;
    end
  end

  assign edge_o = pulse_q;

endmodule

// File: rtl/time_set_controller.sv
// Front-panel editor producing BCD hh:mm and held load strobes for the clock/alarm core.
// Optional button debounce filter enabled by defining ADD_DEBOUNCE_EN.
//
// state     | meaning
// IDLE      | waiting for a mode press; buttons other than mode ignored
// EDIT_HOUR | inc steps hour 00..23, mode moves on, cancel abandons
// EDIT_MIN  | inc steps minute 00..59, mode commits, cancel abandons
// LOAD      | strobe held for LOAD_HOLD_CYCLES, all buttons ignored
module time_set_controller
  import time_set_pkg::*;
#(
  parameter int unsigned LOAD_HOLD_CYCLES = 12,
  parameter int unsigned DEBOUNCE_CYCLES  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_cancel,
  input  logic       alarm_sel,
  input  logic [1:0] cur_hou1,
  input  logic [3:0] cur_hou0,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min0,
  output logic [1:0] hou1,
  output logic [3:0] hou0,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic       loatim,
  output logic       loaala,
  output logic       editing,
  output logic [1:0] field
);

  logic mode_e, inc_e, cancel_e;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clock(clock), .reset(reset), .btn_i(btn_mode), .edge_o(mode_e)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clock(clock), .reset(reset), .btn_i(btn_inc), .edge_o(inc_e)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
    .clock(clock), .reset(reset), .btn_i(btn_cancel), .edge_o(cancel_e)
  );

  state_e     state_q, state_d;
  hhmm_t      edit_q, edit_d;
  logic       tgt_q, tgt_d;
  logic [7:0] hold_q, hold_d;
  hhmm_t      seed;

  assign seed = {cur_hou1, cur_hou0, cur_min1, cur_min0};

  always_comb begin
    state_d = state_q;
    edit_d  = edit_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (mode_e) begin
          edit_d  = seed_ok(seed) ? seed : '0;
          tgt_d   = alarm_sel;
          state_d = EDIT_HOUR;
        end
      end
      EDIT_HOUR: begin
        if (cancel_e)    state_d = IDLE;
        else if (mode_e) state_d = EDIT_MIN;
        else if (inc_e)  edit_d  = hour_inc(edit_q);
      end
      EDIT_MIN: begin
        if (cancel_e) begin
          state_d = IDLE;
        end else if (mode_e) begin
          state_d = LOAD;
          hold_d  = 8'(LOAD_HOLD_CYCLES);
        end else if (inc_e) begin
          edit_d = min_inc(edit_q);
        end
      end
      LOAD: begin
        if (hold_q <= 8'd1) begin
          state_d = IDLE;
          hold_d  = 8'd0;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      edit_q  <= '0;
      tgt_q   <= 1'b0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      edit_q  <= edit_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
    end
  end

  // Strobes decode straight from the state register so reset drops them asynchronously.
  assign loatim  = (state_q == LOAD) && !tgt_q;
  assign loaala  = (state_q == LOAD) && tgt_q;
  assign editing = (state_q == EDIT_HOUR) || (state_q == EDIT_MIN);
  assign field   = state_q;
  assign hou1    = edit_q.h1;
  assign hou0    = edit_q.h0;
  assign min1    = edit_q.m1;
  assign min0    = edit_q.m0;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench with an arithmetic hh:mm model checked every cycle plus literal expectations.
module tb_time_set_controller;

  localparam int LOAD_HOLD = 12;
  localparam int DEB       = 4;
`ifdef ADD_DEBOUNCE_EN
  localparam int PL  = DEB + 2;
  localparam int GAP = DEB + 8;
`else
  localparam int PL  = 1;
  localparam int GAP = 6;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_cancel = 1'b0, alarm_sel = 1'b0;
  logic [1:0] cur_hou1 = '0;
  logic [3:0] cur_hou0 = '0, cur_min1 = '0, cur_min0 = '0;
  logic [1:0] hou1, field;
  logic [3:0] hou0, min1, min0;
  logic       loatim, loaala, editing;

  always #5 clock = ~clock;

  time_set_controller #(.LOAD_HOLD_CYCLES(LOAD_HOLD), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock(clock), .reset(reset),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_cancel(btn_cancel), .alarm_sel(alarm_sel),
    .cur_hou1(cur_hou1), .cur_hou0(cur_hou0), .cur_min1(cur_min1), .cur_min0(cur_min0),
    .hou1(hou1), .hou0(hou0), .min1(min1), .min0(min0),
    .loatim(loatim), .loaala(loaala), .editing(editing), .field(field)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int digits();
    return 1000 * int'(hou1) + 100 * int'(hou0) + 10 * int'(min1) + int'(min0);
  endfunction

  // Model: button edges are the raw rise seen through a fixed pipeline delay,
  // the edit values are plain integers stepped modulo 24 / 60.
  logic [2:0]  raw_d;
  logic [63:0] s2h [3];
  logic [3:0]  lvh [3];
  logic [2:0]  ev;
  logic        ns, nl, same;
  int mst, mh, mm, mtgt, mcnt;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      raw_d = 3'b111;
      for (int b = 0; b < 3; b++) begin
        s2h[b] = '1;
        lvh[b] = '1;
      end
      mst = 0; mh = 0; mm = 0; mtgt = 0; mcnt = 0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        ev[b] = lvh[b][1] & ~lvh[b][2];
        ns = raw_d[b];
`ifdef ADD_DEBOUNCE_EN
        same = 1'b1;
        for (int j = 0; j < DEB; j++) if (s2h[b][j] != s2h[b][0]) same = 1'b0;
        nl = same ? s2h[b][0] : lvh[b][0];
`else
        same = 1'b1;
        nl = ns;
`endif
        s2h[b] = {s2h[b][62:0], ns};
        lvh[b] = {lvh[b][2:0], nl};
      end
      raw_d = {btn_cancel, btn_inc, btn_mode};
      case (mst)
        0: if (ev[0]) begin
          if (cur_hou0 <= 9 && cur_min0 <= 9 && cur_min1 <= 5 &&
              10 * int'(cur_hou1) + int'(cur_hou0) <= 23) begin
            mh = 10 * int'(cur_hou1) + int'(cur_hou0);
            mm = 10 * int'(cur_min1) + int'(cur_min0);
          end else begin
            mh = 0; mm = 0;
          end
          mtgt = int'(alarm_sel);
          mst = 1;
        end
        1: if (ev[2]) mst = 0;
           else if (ev[0]) mst = 2;
           else if (ev[1]) mh = (mh + 1) % 24;
        2: if (ev[2]) mst = 0;
           else if (ev[0]) begin mst = 3; mcnt = LOAD_HOLD; end
           else if (ev[1]) mm = (mm + 1) % 60;
        default: begin
          mcnt--;
          if (mcnt == 0) mst = 0;
        end
      endcase
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("field", int'(field), mst);
      check("editing", int'(editing), (mst == 1 || mst == 2) ? 1 : 0);
      check("loatim", int'(loatim), (mst == 3 && mtgt == 0) ? 1 : 0);
      check("loaala", int'(loaala), (mst == 3 && mtgt == 1) ? 1 : 0);
      check("hou1", int'(hou1), mh / 10);
      check("hou0", int'(hou0), mh % 10);
      check("min1", int'(min1), mm / 10);
      check("min0", int'(min0), mm % 10);
    end
  end

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_mode = v;
      1: btn_inc = v;
      default: btn_cancel = v;
    endcase
  endtask

  task automatic press(input int b, input int len, input int gap);
    set_btn(b, 1'b1);
    repeat (len) @(negedge clock);
    set_btn(b, 1'b0);
    repeat (gap) @(negedge clock);
  endtask

  task automatic seed_in(input int h1, input int h0, input int m1, input int m0);
    cur_hou1 = 2'(h1); cur_hou0 = 4'(h0); cur_min1 = 4'(m1); cur_min0 = 4'(m0);
  endtask

  task automatic count_strobe(input int cycles, output int nt, output int na, output int dig);
    nt = 0; na = 0; dig = -1;
    repeat (cycles) begin
      @(negedge clock);
      if (loatim) nt++;
      if (loaala) na++;
      if ((loatim || loaala) && dig < 0) dig = digits();
    end
  endtask

  int nt, na, dig;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    check("reset field", int'(field), 0);
    check("reset strobes", int'(loatim) + int'(loaala), 0);
    check("reset digits", digits(), 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // 07:30 -> three hour steps -> 10:30 loaded to time
    seed_in(0, 7, 3, 0); alarm_sel = 1'b0;
    press(0, PL, GAP);
    check("t1 enter field", int'(field), 1);
    check("t1 seed", digits(), 730);
    repeat (3) press(1, PL, GAP);
    check("t1 hour steps", digits(), 1030);
    press(0, PL, GAP);
    check("t1 min field", int'(field), 2);
    press(0, PL, 0);
    count_strobe(30 + DEB, nt, na, dig);
    check("t1 loatim cycles", nt, 12);
    check("t1 loaala cycles", na, 0);
    check("t1 load data", dig, 1030);
    check("t1 back idle", int'(field), 0);

    // 23:59 alarm: both fields wrap to 00:00, alarm_sel change mid-edit ignored
    seed_in(2, 3, 5, 9); alarm_sel = 1'b1;
    press(0, PL, GAP);
    alarm_sel = 1'b0;
    check("t2 seed", digits(), 2359);
    press(1, PL, GAP);
    check("t2 hour wrap", digits(), 59);
    press(0, PL, GAP);
    press(1, PL, GAP);
    check("t2 min wrap", digits(), 0);
    press(0, PL, 0);
    count_strobe(30 + DEB, nt, na, dig);
    check("t2 loaala cycles", na, 12);
    check("t2 loatim cycles", nt, 0);
    check("t2 load data", dig, 0);

    // invalid seed 27:15 sanitised
    seed_in(2, 7, 1, 5);
    press(0, PL, GAP);
    check("t3 field", int'(field), 1);
    check("t3 sanitised", digits(), 0);
    press(2, PL, GAP);
    check("t3 cancel", int'(field), 0);

    // cancel beats inc in EDIT_MIN; held inc steps once
    seed_in(1, 2, 4, 5);
    press(0, PL, GAP);
    press(0, PL, GAP);
    check("t4 in min", int'(field), 2);
    btn_cancel = 1'b1; btn_inc = 1'b1;
    repeat (PL) @(negedge clock);
    btn_cancel = 1'b0; btn_inc = 1'b0;
    repeat (GAP) @(negedge clock);
    check("t4 cancel wins", int'(field), 0);
    check("t4 min unchanged", digits(), 1245);
    press(0, PL, GAP);
    press(1, 20, GAP);
    check("t4 held inc", digits(), 1345);
    press(2, PL, GAP);
    press(1, PL, GAP);
    check("t4 idle inc ignored", digits(), 1345);

    // reset in the middle of LOAD
    seed_in(0, 8, 1, 5); alarm_sel = 1'b0;
    press(0, PL, GAP);
    press(0, PL, GAP);
    press(0, PL, 0);
    for (int i = 0; i < 20 + DEB && field != 2'd3; i++) @(negedge clock);
    check("t5 reached load", int'(field), 3);
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    btn_mode = 1'b1;
    #1;
    check("t5 loatim async", int'(loatim), 0);
    check("t5 field async", int'(field), 0);
    check("t5 digits async", digits(), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("t5 held through reset", int'(field), 0);
    btn_mode = 1'b0;
    repeat (GAP) @(negedge clock);

`ifdef ADD_DEBOUNCE_EN
    press(0, 2, 12);
    check("db glitch", int'(field), 0);
    btn_mode = 1'b1;
    repeat (6) @(negedge clock);
    btn_mode = 1'b0;
    @(negedge clock);
    check("db before entry", int'(field), 0);
    @(negedge clock);
    check("db entered", int'(field), 1);
    repeat (GAP) @(negedge clock);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
